// File: rtl/accel_pkg.sv
// rtl/accel_pkg.sv - ADXL345 register map, config values, FSM states and sample type
package accel_pkg;

    localparam logic [7:0] REG_BW_RATE     = 8'h2C;
    localparam logic [7:0] REG_POWER_CTL   = 8'h2D;
    localparam logic [7:0] REG_DATA_FORMAT = 8'h31;
    localparam logic [7:0] REG_DATAX0      = 8'h32;

    localparam logic [7:0] VAL_DATA_FORMAT = 8'h0B;
    localparam logic [7:0] VAL_BW_RATE     = 8'h0A;
    localparam logic [7:0] VAL_POWER_CTL   = 8'h08;

    // R=1, MB=1, start address DATAX0
    localparam logic [7:0] CMD_READ_MB     = 8'hF2;

    localparam int N_CFG        = 3;
    localparam int N_DATA_BYTES = 6;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_CFG_LEAD,
        ST_CFG_XFER,
        ST_GAP,
        ST_IDLE,
        ST_RD_LEAD,
        ST_RD_XFER
    } state_t;

    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic signed [15:0] z;
    } accel_sample_t;

    // Write commands carry R=0, MB=0, so the address byte is the command byte.
    function automatic logic [15:0] cfg_word(input logic [1:0] idx);
        case (idx)
            2'd0:    cfg_word = {REG_DATA_FORMAT, VAL_DATA_FORMAT};
            2'd1:    cfg_word = {REG_BW_RATE, VAL_BW_RATE};
            2'd2:    cfg_word = {REG_POWER_CTL, VAL_POWER_CTL};
            default: cfg_word = 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/spi_byte_master.sv
// rtl/spi_byte_master.sv - mode-3 SPI byte shifter, back-to-back bytes without SCLK gaps
module spi_byte_master #(
    parameter int HALF = 25
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       hold_cs,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic [7:0] rx_byte,
    output logic       done
);

    logic        active;
    logic        phase_high;
    logic [15:0] half_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  tx_sh;
    logic [7:0]  rx_sh;
    logic        half_end;

    assign half_end = active && (half_cnt == 16'(HALF - 1));
    // Combinational so the caller can chain the next byte on the same edge.
    assign done     = half_end && phase_high && (bit_idx == 3'd7);
    assign rx_byte  = rx_sh;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active     <= 1'b0;
            phase_high <= 1'b0;
            half_cnt   <= '0;
            bit_idx    <= '0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            sclk       <= 1'b1;
            mosi       <= 1'b0;
        end else if (!hold_cs) begin
            active   <= 1'b0;
            half_cnt <= '0;
            sclk     <= 1'b1;
            mosi     <= 1'b0;
        end else if (start) begin
            active     <= 1'b1;
            phase_high <= 1'b0;
            half_cnt   <= '0;
            bit_idx    <= '0;
            tx_sh      <= {tx_byte[6:0], 1'b0};
            mosi       <= tx_byte[7];
            sclk       <= 1'b0;
        end else if (active) begin
            if (half_end) begin
                half_cnt <= '0;
                if (!phase_high) begin
                    sclk       <= 1'b1;
                    phase_high <= 1'b1;
                    rx_sh      <= {rx_sh[6:0], miso};
                end else if (bit_idx == 3'd7) begin
                    active <= 1'b0;
                    mosi   <= 1'b0;
                end else begin
                    phase_high <= 1'b0;
                    sclk       <= 1'b0;
                    mosi       <= tx_sh[7];
                    tx_sh      <= {tx_sh[6:0], 1'b0};
                    bit_idx    <= bit_idx + 3'd1;
                end
            end else begin
                half_cnt <= half_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/adxl345_spi_reader.sv
// rtl/adxl345_spi_reader.sv - ADXL345 configuration and periodic X/Y/Z burst reader
module adxl345_spi_reader
    import accel_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int SCLK_HZ   = 1_000_000,
    parameter int SAMPLE_HZ = 100,
    parameter int PWRUP_CYC = 100_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_sdi,
    input  logic        spi_sdo,
    output logic [15:0] data_x,
    output logic [15:0] data_y,
    output logic [15:0] data_z,
    output logic        data_valid,
    output logic        init_done,
    output logic        busy
);

    localparam int HALF = CLK_HZ / (2 * SCLK_HZ);
    localparam int TICK = CLK_HZ / SAMPLE_HZ;

    state_t        state, state_next;
    logic [31:0]   cnt;
    logic [31:0]   tick_cnt;
    logic [1:0]    cfg_idx;
    logic [2:0]    byte_idx;
    logic          cs_n_q;
    logic          init_q;
    logic          dv_q;
    logic          pending;
    logic          tick;
    accel_sample_t sample_q;
    logic [7:0]    rx_buf [0:4];
    logic [15:0]   cfg_w;

    logic          cnt_clr, start, cs_fall, cs_rise, byte_inc, byte_clr;
    logic          cfg_inc, set_init, read_go, store_rx, publish;
    logic [7:0]    tx_byte;
    logic          byte_done, mosi;
    logic [7:0]    rx_byte;

    assign cfg_w = cfg_word(cfg_idx);
    assign tick  = (tick_cnt == 32'(TICK - 1));

    spi_byte_master #(.HALF(HALF)) u_byte (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .hold_cs (~cs_n_q),
        .tx_byte (tx_byte),
        .miso    (spi_sdo),
        .sclk    (spi_sclk),
        .mosi    (mosi),
        .rx_byte (rx_byte),
        .done    (byte_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_PWRUP;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        start      = 1'b0;
        tx_byte    = 8'h00;
        cs_fall    = 1'b0;
        cs_rise    = 1'b0;
        byte_inc   = 1'b0;
        byte_clr   = 1'b0;
        cfg_inc    = 1'b0;
        set_init   = 1'b0;
        read_go    = 1'b0;
        store_rx   = 1'b0;
        publish    = 1'b0;
        case (state)
            ST_PWRUP: begin
                if (cnt == 32'(PWRUP_CYC - 1)) begin
                    state_next = ST_CFG_LEAD;
                    cnt_clr    = 1'b1;
                    cs_fall    = 1'b1;
                end
            end
            ST_CFG_LEAD: begin
                if (cnt == 32'(HALF - 1)) begin
                    start      = 1'b1;
                    tx_byte    = cfg_w[15:8];
                    state_next = ST_CFG_XFER;
                end
            end
            ST_CFG_XFER: begin
                if (byte_done) begin
                    if (byte_idx == 3'd0) begin
                        start    = 1'b1;
                        tx_byte  = cfg_w[7:0];
                        byte_inc = 1'b1;
                    end else begin
                        cs_rise    = 1'b1;
                        byte_clr   = 1'b1;
                        cfg_inc    = 1'b1;
                        set_init   = (cfg_idx == 2'(N_CFG - 1));
                        state_next = ST_GAP;
                        cnt_clr    = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                // Enforces the minimum CS-high time between any two frames.
                if (cnt == 32'(2 * HALF - 1)) begin
                    cnt_clr = 1'b1;
                    if (init_q) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_CFG_LEAD;
                        cs_fall    = 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                if (pending && enable) begin
                    state_next = ST_RD_LEAD;
                    cnt_clr    = 1'b1;
                    cs_fall    = 1'b1;
                    read_go    = 1'b1;
                end
            end
            ST_RD_LEAD: begin
                if (cnt == 32'(HALF - 1)) begin
                    start      = 1'b1;
                    tx_byte    = CMD_READ_MB;
                    state_next = ST_RD_XFER;
                end
            end
            ST_RD_XFER: begin
                if (byte_done) begin
                    store_rx = (byte_idx != 3'd0) && (byte_idx != 3'(N_DATA_BYTES));
                    if (byte_idx == 3'(N_DATA_BYTES)) begin
                        cs_rise    = 1'b1;
                        publish    = 1'b1;
                        byte_clr   = 1'b1;
                        state_next = ST_GAP;
                        cnt_clr    = 1'b1;
                    end else begin
                        start    = 1'b1;
                        byte_inc = 1'b1;
                    end
                end
            end
            default: state_next = ST_PWRUP;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            tick_cnt <= '0;
            cfg_idx  <= '0;
            byte_idx <= '0;
            cs_n_q   <= 1'b1;
            init_q   <= 1'b0;
            dv_q     <= 1'b0;
            pending  <= 1'b0;
            sample_q <= '0;
            for (int i = 0; i < 5; i++) rx_buf[i] <= '0;
        end else begin
            cnt      <= cnt_clr ? '0 : cnt + 32'd1;
            tick_cnt <= tick ? '0 : tick_cnt + 32'd1;
            if (cs_fall)      cs_n_q <= 1'b0;
            else if (cs_rise) cs_n_q <= 1'b1;
            if (byte_inc)      byte_idx <= byte_idx + 3'd1;
            else if (byte_clr) byte_idx <= '0;
            if (cfg_inc)  cfg_idx <= cfg_idx + 2'd1;
            if (set_init) init_q  <= 1'b1;
            if (store_rx) rx_buf[byte_idx - 3'd1] <= rx_byte;
            // Ticks before init are dropped; a tick coinciding with READ start re-arms.
            pending <= (pending && !read_go) || (tick && init_q);
            dv_q    <= publish;
            if (publish) begin
                sample_q.x <= {rx_buf[1], rx_buf[0]};
                sample_q.y <= {rx_buf[3], rx_buf[2]};
                sample_q.z <= {rx_byte, rx_buf[4]};
            end
        end
    end

    assign spi_cs_n   = cs_n_q;
    assign spi_sdi    = mosi && !cs_n_q;
    assign busy       = !cs_n_q;
    assign data_x     = sample_q.x;
    assign data_y     = sample_q.y;
    assign data_z     = sample_q.z;
    assign data_valid = dv_q;
    assign init_done  = init_q;

endmodule

// File: tb/tb_adxl345_spi_reader.sv
// tb/tb_adxl345_spi_reader.sv - randomized bench with behavioural ADXL345 slave and frame timing monitor
module tb_adxl345_spi_reader;

    localparam int CLK_HZ    = 40_000;
    localparam int SCLK_HZ   = 10_000;
    localparam int SAMPLE_HZ = 10;
    localparam int PWRUP_CYC = 200;
    localparam int HALF      = CLK_HZ / (2 * SCLK_HZ);
    localparam int TICK      = CLK_HZ / SAMPLE_HZ;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        spi_cs_n, spi_sclk, spi_sdi;
    logic        spi_sdo = 1'b0;
    logic [15:0] data_x, data_y, data_z;
    logic        data_valid, init_done, busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adxl345_spi_reader #(
        .CLK_HZ(CLK_HZ), .SCLK_HZ(SCLK_HZ), .SAMPLE_HZ(SAMPLE_HZ), .PWRUP_CYC(PWRUP_CYC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_sdi(spi_sdi), .spi_sdo(spi_sdo),
        .data_x(data_x), .data_y(data_y), .data_z(data_z),
        .data_valid(data_valid), .init_done(init_done), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Behavioural ADXL345: register file, write log, mode-3 shifting
    logic [7:0]  sreg [0:63];
    logic [15:0] wr_q [$];
    logic [7:0]  s_cmd = 8'h00;
    logic [7:0]  s_sh  = 8'h00;
    int          s_bits = 0;
    bit          s_active = 0;

    always @(negedge spi_cs_n, posedge spi_cs_n, posedge spi_sclk, negedge spi_sclk) begin
        if (spi_cs_n) begin
            s_active = 0;
        end else if (!s_active) begin
            s_active = 1;
            s_bits   = 0;
        end else if (spi_sclk) begin
            s_sh = {s_sh[6:0], spi_sdi};
            s_bits++;
            if (s_bits % 8 == 0) begin
                if (s_bits == 8) s_cmd = s_sh;
                else if (!s_cmd[7]) wr_q.push_back({s_cmd, s_sh});
            end
        end else if (s_bits >= 8 && s_cmd[7]) begin
            spi_sdo = sreg[int'(s_cmd[5:0]) + s_bits / 8 - 1][7 - s_bits % 8];
        end
    end

    // Frame timing monitor, sampled on the falling clock edge
    logic prev_cs = 1, prev_sclk = 1, prev_sdi = 0, prev_dv = 0, prev_init = 0;
    int   cs_fall_cyc, cs_rise_cyc, last_rise_cyc;
    int   cur_rises = 0, frames = 0, dv_count = 0;
    int   sclk_idle_bad = 0, sdi_idle_bad = 0, dv_wide = 0;
    bit   in_frame = 0, first_fall = 0, have_prev = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            in_frame  = 0;
            have_prev = 0;
        end else begin
            if (prev_cs && !spi_cs_n) begin
                if (have_prev) check("cs_gap", 64'(cyc - cs_rise_cyc >= 2 * HALF), 64'd1);
                in_frame    = 1;
                first_fall  = 1;
                cur_rises   = 0;
                cs_fall_cyc = cyc;
            end
            if (!spi_cs_n && in_frame) begin
                if (first_fall && prev_sclk && !spi_sclk) begin
                    check("cs_to_sclk", 64'(cyc - cs_fall_cyc), 64'(HALF));
                    first_fall = 0;
                end
                if (!prev_sclk && spi_sclk) begin
                    cur_rises++;
                    last_rise_cyc = cyc;
                    check("mosi_stable", 64'(spi_sdi), 64'(prev_sdi));
                end
            end
            if (!prev_cs && spi_cs_n && in_frame) begin
                check("frame_bits", 64'(cur_rises == 16 || cur_rises == 56), 64'd1);
                check("sclk_to_cs", 64'(cyc - last_rise_cyc), 64'(HALF));
                in_frame    = 0;
                have_prev   = 1;
                cs_rise_cyc = cyc;
                frames++;
            end
            if (spi_cs_n && !spi_sclk) sclk_idle_bad++;
            if (spi_cs_n && spi_sdi)   sdi_idle_bad++;
            if (data_valid) begin
                dv_count++;
                check("dv_on_cs_rise", {62'd0, prev_cs, spi_cs_n}, 64'd1);
                if (prev_dv) dv_wide++;
            end
            if (init_done && !prev_init) check("init_on_cs_rise", {62'd0, prev_cs, spi_cs_n}, 64'd1);
        end
        prev_cs   = spi_cs_n;
        prev_sclk = spi_sclk;
        prev_sdi  = spi_sdi;
        prev_dv   = data_valid;
        prev_init = init_done;
    end

    // Reference model: little-endian 16-bit words from the burst start address
    function automatic logic [47:0] model_sample();
        return {sreg[8'h33], sreg[8'h32], sreg[8'h35], sreg[8'h34], sreg[8'h37], sreg[8'h36]};
    endfunction

    task automatic check_sample(input string tag);
        logic [47:0] exp;
        exp = model_sample();
        check({tag, "_x"}, 64'(data_x), 64'(exp[47:32]));
        check({tag, "_y"}, 64'(data_y), 64'(exp[31:16]));
        check({tag, "_z"}, 64'(data_z), 64'(exp[15:0]));
    endtask

    task automatic set_data_regs(input logic [47:0] bytes_le);
        for (int i = 0; i < 6; i++) sreg[8'h32 + i] = bytes_le[47 - 8 * i -: 8];
    endtask

    task automatic randomize_data_regs();
        for (int i = 0; i < 6; i++) sreg[8'h32 + i] = 8'($urandom);
    endtask

    task automatic wait_dv(input int budget, output bit ok, output int at);
        ok = 0;
        at = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (data_valid) begin
                ok = 1;
                at = cyc;
            end
        end
    endtask

    task automatic wait_init(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (init_done) ok = 1;
        end
    endtask

    task automatic wait_cs_low(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (!spi_cs_n) ok = 1;
        end
    endtask

    task automatic check_writes();
        logic [15:0] exp_w [3];
        exp_w[0] = 16'h310B;
        exp_w[1] = 16'h2C0A;
        exp_w[2] = 16'h2D08;
        check("wr_count", 64'(wr_q.size()), 64'd3);
        for (int i = 0; i < 3; i++)
            if (i < wr_q.size()) check($sformatf("wr_%0d", i), 64'(wr_q[i]), 64'(exp_w[i]));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cs_n"}, 64'(spi_cs_n), 64'd1);
        check({tag, "_sclk"}, 64'(spi_sclk), 64'd1);
        check({tag, "_sdi"}, 64'(spi_sdi), 64'd0);
        check({tag, "_data"}, {16'd0, data_x, data_y, data_z}, 64'd0);
        check({tag, "_dv"}, 64'(data_valid), 64'd0);
        check({tag, "_init"}, 64'(init_done), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        bit ok;
        int t_dv, t_prev, f0, dv0;
        localparam int INIT_BUDGET = PWRUP_CYC + 3 * 40 * HALF + 200;
        localparam int READ_BUDGET = TICK + 130 * HALF + 50;

        reset_n = 1'b0;
        enable  = 1'b0;
        for (int i = 0; i < 64; i++) sreg[i] = 8'($urandom);
        repeat (3) @(negedge clk);
        check_reset_values("reset");

        // Power-up and configuration
        reset_n = 1'b1;
        wait_init(INIT_BUDGET, ok);
        check("init_seen", 64'(ok), 64'd1);
        check_writes();

        // Positive sample, then randomized back-to-back samples at the tick rate
        set_data_regs(48'h23_01_56_04_89_07);
        enable = 1'b1;
        wait_dv(READ_BUDGET, ok, t_dv);
        check("dv_first", 64'(ok), 64'd1);
        check("read_cmd", 64'(s_cmd), 64'hF2);
        check_sample("pos");
        for (int k = 0; k < 3; k++) begin
            randomize_data_regs();
            t_prev = t_dv;
            wait_dv(READ_BUDGET, ok, t_dv);
            check("dv_rand", 64'(ok), 64'd1);
            check("tick_period", 64'(t_dv - t_prev), 64'(TICK));
            check_sample("rand");
        end

        // Negative values
        set_data_regs(48'h1B_FA_2D_FC_3F_FE);
        wait_dv(READ_BUDGET, ok, t_dv);
        check("dv_neg", 64'(ok), 64'd1);
        check_sample("neg");

        // enable dropped mid-read: the read completes, then the bus stays quiet
        randomize_data_regs();
        wait_cs_low(READ_BUDGET, ok);
        check("cs_low_en", 64'(ok), 64'd1);
        repeat (30) @(negedge clk);
        enable = 1'b0;
        wait_dv(130 * HALF, ok, t_dv);
        check("dv_after_disable", 64'(ok), 64'd1);
        check_sample("dis");
        repeat (2) @(negedge clk);
        f0 = frames;
        repeat (3 * TICK) @(negedge clk);
        check("quiet_while_disabled", 64'(frames - f0), 64'd0);
        randomize_data_regs();
        enable = 1'b1;
        wait_dv(READ_BUDGET, ok, t_dv);
        check("dv_resume", 64'(ok), 64'd1);
        check_sample("resume");

        // Reset at bit 20 of a read
        randomize_data_regs();
        wait_cs_low(READ_BUDGET, ok);
        check("cs_low_rst", 64'(ok), 64'd1);
        ok = 0;
        for (int i = 0; i < 60 * HALF && !ok; i++) begin
            @(negedge clk);
            if (cur_rises >= 20) ok = 1;
        end
        check("reached_bit20", 64'(ok), 64'd1);
        reset_n = 1'b0;
        #1;
        check_reset_values("midrst");
        dv0 = dv_count;
        wr_q.delete();
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        wait_init(INIT_BUDGET, ok);
        check("reinit_seen", 64'(ok), 64'd1);
        check_writes();
        check("no_dv_after_abort", 64'(dv_count - dv0), 64'd0);
        check("reinit_data_clear", {16'd0, data_x, data_y, data_z}, 64'd0);

        check("sclk_high_when_idle", 64'(sclk_idle_bad), 64'd0);
        check("sdi_low_when_idle", 64'(sdi_idle_bad), 64'd0);
        check("dv_single_cycle", 64'(dv_wide), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
